// File: rtl/reel_spin_ctrl.sv
// reel_spin_ctrl -- three-reel slot-machine sequencer.
//
// Sits between the random digit generator and the digit-to-matrix
// converters. A start pulse spins all three reels. Every TICK_DIV clocks
// each moving reel steps by one, wrapping from 7 to 0. The reels then stop
// from left to right, and each one loads rnd_in on its stop tick. When the
// right reel has stopped, a one-cycle RESULT state pulses done. win and pair
// are valid in that same cycle.
//
// Ports:
//   clk       master clock
//   rst       synchronous active-high reset
//   start     one-cycle start pulse (ignored unless idle)
//   rnd_in    current random digit 0-7
//   rnd_en    random generator enable, high whenever not idle
//   reel1..3  left / middle / right reel digits
//   spinning  high while any reel is moving
//   done      one-cycle pulse, result valid
//   win       all three reels equal, held until next start or reset
//   pair      exactly two reels equal, held until next start or reset
module reel_spin_ctrl #(
  parameter int unsigned TICK_DIV       = 5000000,
  parameter int unsigned SPIN_TICKS     = 40,
  parameter int unsigned STOP_GAP_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] rnd_in,
  output logic       rnd_en,
  output logic [2:0] reel1,
  output logic [2:0] reel2,
  output logic [2:0] reel3,
  output logic       spinning,
  output logic       done,
  output logic       win,
  output logic       pair
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPIN_ALL,
    ST_SPIN_23,
    ST_SPIN_3,
    ST_RESULT
  } state_e;

  localparam int unsigned PH_MAX = (SPIN_TICKS > STOP_GAP_TICKS) ? SPIN_TICKS : STOP_GAP_TICKS;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]   SPIN_LAST = PH_W'(SPIN_TICKS - 1);
  localparam logic [PH_W-1:0]   GAP_LAST  = PH_W'(STOP_GAP_TICKS - 1);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [2:0]        reel1_q, reel1_d;
  logic [2:0]        reel2_q, reel2_d;
  logic [2:0]        reel3_q, reel3_d;
  logic              win_q, win_d;
  logic              pair_q, pair_d;

  logic              spin_state;
  logic              tick;
  logic              stop_tick;
  logic [PH_W-1:0]   phase_last;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    phase_cnt_d = phase_cnt_q;
    reel1_d     = reel1_q;
    reel2_d     = reel2_q;
    reel3_d     = reel3_q;
    win_d       = win_q;
    pair_d      = pair_q;

    spin_state = (state_q == ST_SPIN_ALL) || (state_q == ST_SPIN_23) ||
                 (state_q == ST_SPIN_3);
    tick       = spin_state && (tick_cnt_q == TICK_LAST);
    phase_last = (state_q == ST_SPIN_ALL) ? SPIN_LAST : GAP_LAST;
    // The stop tick is the last tick of the phase. On that tick the
    // stopping reel loads rnd_in instead of stepping.
    stop_tick  = tick && (phase_cnt_q == phase_last);

    // Both counters run only while spinning. Outside the spin states
    // they are parked at zero, so each spin starts from a clean phase.
    if (spin_state) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      if (tick) begin
        phase_cnt_d = stop_tick ? '0 : phase_cnt_q + PH_W'(1);
      end
    end else begin
      tick_cnt_d  = '0;
      phase_cnt_d = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SPIN_ALL;
          win_d   = 1'b0;
          pair_d  = 1'b0;
        end
      end
      ST_SPIN_ALL: begin
        if (tick) begin
          reel1_d = stop_tick ? rnd_in : reel1_q + 3'd1;
          reel2_d = reel2_q + 3'd1;
          reel3_d = reel3_q + 3'd1;
          if (stop_tick) state_d = ST_SPIN_23;
        end
      end
      ST_SPIN_23: begin
        if (tick) begin
          reel2_d = stop_tick ? rnd_in : reel2_q + 3'd1;
          reel3_d = reel3_q + 3'd1;
          if (stop_tick) state_d = ST_SPIN_3;
        end
      end
      ST_SPIN_3: begin
        if (tick) begin
          reel3_d = stop_tick ? rnd_in : reel3_q + 3'd1;
          if (stop_tick) begin
            state_d = ST_RESULT;
            // Evaluate the flags from the final reel values, which include
            // the reel3 value loaded on this edge. This makes them valid
            // together with done.
            win_d  = (reel1_q == reel2_q) && (reel2_q == reel3_d);
            pair_d = !((reel1_q == reel2_q) && (reel2_q == reel3_d)) &&
                     ((reel1_q == reel2_q) || (reel2_q == reel3_d) ||
                      (reel1_q == reel3_d));
          end
        end
      end
      ST_RESULT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples the pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      phase_cnt_q <= '0;
      reel1_q     <= '0;
      reel2_q     <= '0;
      reel3_q     <= '0;
      win_q       <= 1'b0;
      pair_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      reel1_q     <= reel1_d;
      reel2_q     <= reel2_d;
      reel3_q     <= reel3_d;
      win_q       <= win_d;
      pair_q      <= pair_d;
    end
  end

  assign reel1    = reel1_q;
  assign reel2    = reel2_q;
  assign reel3    = reel3_q;
  assign spinning = spin_state;
  assign rnd_en   = (state_q != ST_IDLE);
  assign done     = (state_q == ST_RESULT);
  assign win      = win_q;
  assign pair     = pair_q;

endmodule
